// File: rtl/ts_pkg.sv
// Shared MPEG-TS constants and framer state encoding, also used by the
// downstream PID monitor stage.
package ts_pkg;

    localparam int         TS_PACK_BYTE_SIZE = 188;
    localparam logic [7:0] TS_SYNC_BYTE      = 8'h47;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } ts_state_e;

endpackage

// File: rtl/ts_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones once full.
module ts_sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != '1)) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/ts_sync_locker.sv
// MPEG-TS sync framer: hunts for the sync byte at packet spacing, locks after
// LOCK_COUNT hits and flywheels out_sync. Optional stats: TS_SYNC_LOCKER_STATS_EN.
module ts_sync_locker
    import ts_pkg::*;
#(
    parameter int         PACK_BYTE_SIZE     = TS_PACK_BYTE_SIZE,
    parameter logic [7:0] SYNC_BYTE          = TS_SYNC_BYTE,
    parameter int         LOCK_COUNT         = 3,
    parameter int         UNLOCK_COUNT       = 3,
    parameter int         C_S_AXI_DATA_WIDTH = 32
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [7:0]                    in_data,
    input  logic                          in_valid,
    output logic [7:0]                    out_data,
    output logic                          out_valid,
    output logic                          out_sync,
    output logic                          locked,
    output logic [C_S_AXI_DATA_WIDTH-1:0] sync_loss_count
`ifdef TS_SYNC_LOCKER_STATS_EN
    ,
    output logic [C_S_AXI_DATA_WIDTH-1:0] packet_count,
    output logic [C_S_AXI_DATA_WIDTH-1:0] sync_error_count
`endif
);

    localparam logic [7:0] LAST_POS   = 8'(PACK_BYTE_SIZE - 1);
    localparam logic [3:0] LOCK_CNT   = 4'(LOCK_COUNT);
    localparam logic [3:0] UNLOCK_CNT = 4'(UNLOCK_COUNT);

    ts_state_e  state_q, state_d;
    logic [7:0] byte_pos_q, byte_pos_d;
    logic [3:0] good_q, good_d;
    logic [3:0] miss_q, miss_d;
    logic [7:0] out_data_q;
    logic       out_valid_q;
    logic       out_sync_q, out_sync_d;
    logic       locked_q;

    logic       is_sync;
    logic       at_boundary;
    logic       unlock_evt;
    logic [3:0] good_inc;
    logic [3:0] miss_inc;

    assign is_sync     = (in_data == SYNC_BYTE);
    assign at_boundary = (byte_pos_q == 8'd0);
    assign good_inc    = good_q + 4'd1;
    assign miss_inc    = miss_q + 4'd1;

    // NOTE: every signal written here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        state_d    = state_q;
        byte_pos_d = byte_pos_q;
        good_d     = good_q;
        miss_d     = miss_q;
        out_sync_d = 1'b0;
        unlock_evt = 1'b0;

        if (in_valid) begin
            byte_pos_d = (byte_pos_q == LAST_POS) ? 8'd0 : byte_pos_q + 8'd1;
            unique case (state_q)
                HUNT: begin
                    if (is_sync) begin
                        state_d    = VERIFY;
                        byte_pos_d = 8'd1;
                        good_d     = 4'd1;
                    end
                end
                VERIFY: begin
                    // A failed boundary byte is dropped, not retried as a candidate.
                    if (at_boundary) begin
                        if (is_sync) begin
                            good_d = good_inc;
                            if (good_inc == LOCK_CNT) begin
                                state_d    = LOCKED;
                                miss_d     = 4'd0;
                                out_sync_d = 1'b1;
                            end
                        end else begin
                            state_d = HUNT;
                        end
                    end
                end
                LOCKED: begin
                    if (at_boundary) begin
                        out_sync_d = 1'b1;
                        if (is_sync) begin
                            miss_d = 4'd0;
                        end else if (miss_inc == UNLOCK_CNT) begin
                            state_d    = HUNT;
                            miss_d     = 4'd0;
                            unlock_evt = 1'b1;
                        end else begin
                            miss_d = miss_inc;
                        end
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops sample
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= HUNT;
            byte_pos_q  <= 8'd0;
            good_q      <= 4'd0;
            miss_q      <= 4'd0;
            out_data_q  <= 8'd0;
            out_valid_q <= 1'b0;
            out_sync_q  <= 1'b0;
            locked_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            byte_pos_q  <= byte_pos_d;
            good_q      <= good_d;
            miss_q      <= miss_d;
            out_data_q  <= in_data;
            out_valid_q <= in_valid;
            out_sync_q  <= out_sync_d;
            locked_q    <= (state_d == LOCKED);
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_sync  = out_sync_q;
    assign locked    = locked_q;

    ts_sat_counter #(.WIDTH(C_S_AXI_DATA_WIDTH)) u_loss_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (1'b0),
        .inc   (unlock_evt),
        .count (sync_loss_count)
    );

`ifdef TS_SYNC_LOCKER_STATS_EN
    ts_sat_counter #(.WIDTH(C_S_AXI_DATA_WIDTH)) u_pkt_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (1'b0),
        .inc   (out_sync_d),
        .count (packet_count)
    );

    ts_sat_counter #(.WIDTH(C_S_AXI_DATA_WIDTH)) u_err_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (1'b0),
        .inc   (in_valid && (state_q == LOCKED) && at_boundary && !is_sync),
        .count (sync_error_count)
    );
`else
    // Statistics disabled: no extra counters or ports.
`endif

endmodule

// File: tb/tb_ts_sync_locker.sv
// Self-checking bench for ts_sync_locker: per-cycle compare against a
// packet-phase model plus literal lock-point expectations.
module tb_ts_sync_locker;

    localparam int         P  = 188;
    localparam logic [7:0] SB = 8'h47;
    localparam int         LC = 3;
    localparam int         UC = 3;

    localparam int M_HUNT   = 0;
    localparam int M_VERIFY = 1;
    localparam int M_LOCKED = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  in_data = 8'd0;
    logic        in_valid = 1'b0;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_sync;
    logic        locked;
    logic [31:0] sync_loss_count;
`ifdef TS_SYNC_LOCKER_STATS_EN
    logic [31:0] packet_count;
    logic [31:0] sync_error_count;
`endif

    always #5 clk = ~clk;

    ts_sync_locker dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .in_data         (in_data),
        .in_valid        (in_valid),
        .out_data        (out_data),
        .out_valid       (out_valid),
        .out_sync        (out_sync),
        .locked          (locked),
        .sync_loss_count (sync_loss_count)
`ifdef TS_SYNC_LOCKER_STATS_EN
        ,
        .packet_count     (packet_count),
        .sync_error_count (sync_error_count)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: boundary is "a multiple of P valid bytes after the accepted candidate".
    int         m_mode, m_anchor, m_vidx, m_conf, m_miss;
    logic [7:0] e_data;
    logic       e_valid, e_sync, e_locked;
    int         e_loss, e_pkt, e_err;

    task automatic model(input logic [7:0] d, input logic v, input logic r);
        bit at;
        if (!r) begin
            m_mode = M_HUNT; m_anchor = 0; m_vidx = 0; m_conf = 0; m_miss = 0;
            e_data = 8'd0; e_valid = 1'b0; e_sync = 1'b0; e_locked = 1'b0;
            e_loss = 0; e_pkt = 0; e_err = 0;
            return;
        end
        e_data  = d;
        e_valid = v;
        e_sync  = 1'b0;
        if (v) begin
            at = (((m_vidx - m_anchor) % P) == 0);
            if (m_mode == M_HUNT) begin
                if (d == SB) begin
                    m_mode = M_VERIFY; m_anchor = m_vidx; m_conf = 1;
                end
            end else if (m_mode == M_VERIFY) begin
                if (at) begin
                    if (d == SB) begin
                        m_conf++;
                        if (m_conf == LC) begin
                            m_mode = M_LOCKED; m_miss = 0; e_sync = 1'b1;
                        end
                    end else begin
                        m_mode = M_HUNT;
                    end
                end
            end else begin
                if (at) begin
                    e_sync = 1'b1;
                    if (d == SB) m_miss = 0;
                    else begin
                        m_miss++;
                        e_err++;
                        if (m_miss == UC) begin
                            m_mode = M_HUNT; m_miss = 0; e_loss++;
                        end
                    end
                end
            end
            m_vidx++;
        end
        e_locked = (m_mode == M_LOCKED);
        if (e_sync) e_pkt++;
    endtask

    int obs_idx, obs_first_lock, obs_syncs, obs_first_sync, obs_last_sync, obs_sync_novalid;

    task automatic new_test();
        obs_idx = 0; obs_first_lock = -1; obs_syncs = 0;
        obs_first_sync = -1; obs_last_sync = -1; obs_sync_novalid = 0;
    endtask

    task automatic step(input logic [7:0] d, input logic v, input logic r);
        in_data = d; in_valid = v; rst_n = r;
        @(posedge clk);
        model(d, v, r);
        #1;
        check("out_data", {24'd0, out_data}, {24'd0, e_data});
        check("out_valid", {31'd0, out_valid}, {31'd0, e_valid});
        check("out_sync", {31'd0, out_sync}, {31'd0, e_sync});
        check("locked", {31'd0, locked}, {31'd0, e_locked});
        check("sync_loss_count", sync_loss_count, e_loss);
`ifdef TS_SYNC_LOCKER_STATS_EN
        check("packet_count", packet_count, e_pkt);
        check("sync_error_count", sync_error_count, e_err);
`endif
        if (out_sync && !out_valid) obs_sync_novalid++;
        if (out_valid) begin
            if (locked && obs_first_lock < 0) obs_first_lock = obs_idx;
            if (out_sync) begin
                if (obs_first_sync < 0) obs_first_sync = obs_idx;
                obs_last_sync = obs_idx;
                obs_syncs++;
            end
            obs_idx++;
        end
    endtask

    function automatic logic [7:0] payload();
        logic [7:0] b;
        b = 8'($urandom_range(0, 255));
        if (b == SB) b = 8'h00;
        return b;
    endfunction

    task automatic send_pkt(input logic [7:0] first, input int gap_pct);
        for (int k = 0; k < P; k++) begin
            while (gap_pct > 0 && $urandom_range(0, 99) < gap_pct)
                step(8'($urandom_range(0, 255)), 1'b0, 1'b1);
            step((k == 0) ? first : payload(), 1'b1, 1'b1);
        end
    endtask

    task automatic do_reset();
        step(8'h00, 1'b0, 1'b0);
        step(SB, 1'b1, 1'b0);
        new_test();
    endtask

    initial begin
        new_test();

        // Reset state
        do_reset();
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_locked", {31'd0, locked}, 32'd0);
        check("rst_loss", sync_loss_count, 32'd0);

        // Clean stream: lock on third sync, pulses on syncs 2..4
        for (int p = 0; p < 5; p++) send_pkt(SB, 0);
        check("clean_lock_idx", obs_first_lock, 376);
        check("clean_sync_cnt", obs_syncs, 3);
        check("clean_first_sync", obs_first_sync, 376);
        check("clean_last_sync", obs_last_sync, 752);

        // False sync at offset 50, true packets start at 100
        do_reset();
        for (int i = 0; i < 100 + 4 * P; i++) begin
            if (i == 50 || (i >= 100 && ((i - 100) % P) == 0)) step(SB, 1'b1, 1'b1);
            else step(payload(), 1'b1, 1'b1);
        end
        check("false_lock_idx", obs_first_lock, 664);
        check("false_loss", sync_loss_count, 32'd0);

        // Flywheel: 2 misses held, 3 misses drop lock
        do_reset();
        for (int p = 0; p < 3; p++) send_pkt(SB, 0);
        send_pkt(8'h00, 0);
        send_pkt(8'h00, 0);
        check("fly_hold_locked", {31'd0, locked}, 32'd1);
        send_pkt(SB, 0);
        send_pkt(SB, 0);
        send_pkt(8'h00, 0);
        send_pkt(8'h00, 0);
        check("fly_loss_before", sync_loss_count, 32'd0);
        send_pkt(8'h00, 0);
        check("fly_dropped", {31'd0, locked}, 32'd0);
        check("fly_loss_after", sync_loss_count, 32'd1);
        check("fly_sync_cnt", obs_syncs, 8);

        // Gapped valid: same lock point in valid bytes
        do_reset();
        for (int p = 0; p < 5; p++) send_pkt(SB, 50);
        check("gap_lock_idx", obs_first_lock, 376);
        check("gap_sync_cnt", obs_syncs, 3);
        check("gap_sync_novalid", obs_sync_novalid, 0);

        // Reset mid-packet at byte 100 of a locked stream
        do_reset();
        for (int p = 0; p < 3; p++) send_pkt(SB, 0);
        step(SB, 1'b1, 1'b1);
        for (int k = 1; k < 100; k++) step(payload(), 1'b1, 1'b1);
        check("pre_rst_locked", {31'd0, locked}, 32'd1);
        step(payload(), 1'b1, 1'b0);
        check("mid_rst_data", {24'd0, out_data}, 32'd0);
        check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        check("mid_rst_sync", {31'd0, out_sync}, 32'd0);
        check("mid_rst_locked", {31'd0, locked}, 32'd0);
        new_test();
        for (int k = 101; k < P; k++) step(payload(), 1'b1, 1'b1);
        for (int p = 0; p < 3; p++) send_pkt(SB, 0);
        check("relock_idx", obs_first_lock, 463);
        check("relock_sync_cnt", obs_syncs, 1);

`ifdef TS_SYNC_LOCKER_STATS_EN
        // Stats: 10 clean syncs from lock onward plus one corrupted sync
        do_reset();
        for (int p = 0; p < 12; p++) send_pkt(SB, 0);
        send_pkt(8'h00, 0);
        check("stats_pkt", packet_count, 32'd11);
        check("stats_err", sync_error_count, 32'd1);
        check("stats_locked", {31'd0, locked}, 32'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ts_sync_locker.md
Name: ts_sync_locker

Overview:
Byte-stream framer that sits directly upstream of the PID monitor/capture stage. It takes a raw 8-bit MPEG-TS byte stream with a byte-valid strobe and hunts for the 0x47 sync byte at 188-byte spacing. After a configurable number of confirmations it declares lock and regenerates a clean per-packet sync marker. Its outputs drive the monitor's mpeg_data / mpeg_valid / mpeg_sync inputs. It runs entirely in the MPEG byte-clock domain.

Parameters:
PACK_BYTE_SIZE, 188, packet length in bytes; legal range 2..255.
SYNC_BYTE, 8'h47, sync byte value.
LOCK_COUNT, 3, consecutive correctly spaced sync bytes required to enter LOCKED (including the first); legal range 2..15.
UNLOCK_COUNT, 3, consecutive missing sync bytes in LOCKED that force a return to HUNT; legal range 1..15.
C_S_AXI_DATA_WIDTH, 32, width of the status counters.

Ports:
clk  in  1  MPEG byte clock.
rst_n  in  1  synchronous, active-low reset.
in_data  in  8  raw TS byte.
in_valid  in  1  in_data is valid this cycle.
out_data  out  8  registered copy of in_data.
out_valid  out  1  registered copy of in_valid.
out_sync  out  1  marks the packet-start byte on out_data; asserted only while locked.
locked  out  1  state == LOCKED.
sync_loss_count  out  C_S_AXI_DATA_WIDTH  number of LOCKED->HUNT transitions; saturates at all-ones.

Behaviour:
- Reset: rst_n sampled on the clk edge. All outputs go to 0, state goes to HUNT, and all internal counters clear. Reset mid-packet discards all alignment.
- Only cycles with in_valid=1 advance any state or counter. In_valid=0 cycles are fully transparent apart from the output pipeline.
- Output latency is exactly 1 cycle: out_data, out_valid and out_sync update on every clk edge from the current inputs and state.
- byte_pos: 8-bit counter. Incremented on each valid byte, wrapping from PACK_BYTE_SIZE-1 to 0. A valid byte is "at boundary" when byte_pos == 0 on arrival.
- HUNT:
  - A valid byte equal to SYNC_BYTE moves the block to VERIFY, sets byte_pos to 1 and good to 1.
  - Any other byte is ignored.
- VERIFY (at a boundary byte):
  - If the byte equals SYNC_BYTE, good increments. When good reaches LOCK_COUNT, move to LOCKED and clear miss.
  - If the byte does not equal SYNC_BYTE, return to HUNT. That byte is not re-examined as a new candidate.
- LOCKED (at a boundary byte):
  - out_sync is asserted with that byte (flywheel behaviour: asserted even if the byte is not SYNC_BYTE).
  - If the byte equals SYNC_BYTE, miss clears.
  - Otherwise miss increments. When miss reaches UNLOCK_COUNT, move to HUNT, increment sync_loss_count (saturating) and clear miss.
  - byte_pos is never re-phased while LOCKED.
- The boundary byte that completes the lock (VERIFY->LOCKED) also gets out_sync=1.
- The boundary byte that causes the unlock (LOCKED->HUNT) gets out_sync=1.
- out_sync is never asserted when out_valid=0.
- locked is registered and changes in the same cycle as the out_sync of the transition byte.

Optional Feature:
Macro TS_SYNC_LOCKER_STATS_EN.
- Defined: adds two output ports, packet_count [C_S_AXI_DATA_WIDTH] and sync_error_count [C_S_AXI_DATA_WIDTH].
  - packet_count increments on every out_sync.
  - sync_error_count increments on every LOCKED boundary byte that is not SYNC_BYTE.
  - Both saturate and are cleared by reset.
- Undefined: these ports and counters do not exist. All other behaviour is identical.

Decomposition:
- Shared package ts_pkg holds:
  - TS_PACK_BYTE_SIZE (188)
  - TS_SYNC_BYTE (8'h47)
  - the state enum: HUNT=0, VERIFY=1, LOCKED=2
- These constants are shared with the monitor stage.
- One sub-module is natural: ts_sat_counter, a parameterised-width saturating incrementer with synchronous clear. It is used for sync_loss_count and the optional statistics counters.

Test Plan:
- Clean stream:
  - Stimulus: 5 packets of 188 bytes, each starting with 0x47, in_valid always 1.
  - Expected: locked rises with output byte 376 (the third sync, 0-based). out_sync pulses at output bytes 376, 564 and 752 only. out_data equals in_data delayed by 1 cycle.
- False sync:
  - Stimulus: 0x47 at offset 50 of the payload, followed by a correct stream.
  - Expected: VERIFY fails at offset 238 and the block returns to HUNT. It then locks on the true sync after 3 packets; sync_loss_count stays 0.
- Flywheel and loss:
  - Stimulus: locked stream; corrupt 2 consecutive sync bytes to 0x00, then restore.
  - Expected: locked stays 1 and out_sync still pulses on the corrupted bytes. Corrupting 3 consecutive sync bytes drops locked on the third and sets sync_loss_count = 1.
- Gapped valid:
  - Stimulus: in_valid randomly low 50% of cycles on a clean stream.
  - Expected: same lock point counted in valid bytes. out_valid mirrors in_valid 1 cycle late, and no out_sync occurs while out_valid=0.
- Reset mid-packet:
  - Stimulus: assert rst_n=0 for 1 cycle at byte 100 of a locked stream.
  - Expected: all outputs are 0 the next cycle. Relock requires 3 further syncs.
- Stats (TS_SYNC_LOCKER_STATS_EN):
  - Stimulus: 10 clean packets after lock, plus 1 corrupted sync.
  - Expected: packet_count = 11 and sync_error_count = 1.
